readback_selector: RTL and testbench

Registered, parametrised read-back multiplexer for the counter board's register bus. It decodes a read address into the version, DAC, and counter regions. Reads of multi-byte counter channels are made coherent with an atomic snapshot. Each read is acknowledged one cycle after request. It sits between the host bus interface and the counter/DAC register banks, replacing the purely combinational address selector.

---
 rtl/readback_selector.sv | 162 ++++++++++++++++
 tb/tb_readback_selector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/readback_selector.sv
// Purpose : registered read-back mux for the counter board register bus (version, DAC, counter regions),
//           with an optional coherent snapshot of multi-byte counter channels (macro READBACK_SNAPSHOT_EN).
// Latency : 1 cycle, request at edge n -> rd_valid/rd_data/rd_err after edge n+1. No backpressure, full rate.
// Ports   : clk, rst_n (async, active-low); rd_req/rd_addr request; dac_data/cnt_data register banks;
//           rd_valid/rd_data/rd_err response (rd_data/rd_err hold their last values while rd_valid=0).
module readback_selector #(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [DATA_W-1:0]  VERSION  = 8'h01,
  parameter logic [ADDR_W-1:0]  DAC_BASE = 8'h02,
  parameter int unsigned        N_DAC    = 5,
  parameter logic [ADDR_W-1:0]  CNT_BASE = 8'h26,
  parameter int unsigned        N_CNT    = 32,
  parameter int unsigned        CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [N_DAC*DATA_W-1:0] dac_data,
  input  logic [N_CNT*CNT_W-1:0]  cnt_data,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_err
);

  localparam int unsigned B        = CNT_W / DATA_W;
  localparam int unsigned DAC_LO   = 32'(DAC_BASE);
  localparam int unsigned DAC_HI   = DAC_LO + N_DAC - 1;
  localparam int unsigned CNT_LO   = 32'(CNT_BASE);
  localparam int unsigned CNT_HI   = CNT_LO + N_CNT * B - 1;
  localparam int unsigned ADDR_MAX = (2 ** ADDR_W) - 1;
  localparam int unsigned CH_W     = (N_CNT > 1) ? $clog2(N_CNT) : 1;

  // Map sanity: anything wrong here would silently alias registers, so stop elaboration.
  if ((B == 0) || (CNT_W % DATA_W != 0)) begin : g_chk_cnt_w
    $error("CNT_W must be a non-zero multiple of DATA_W");
  end
  if ((N_DAC == 0) || (N_CNT == 0)) begin : g_chk_sizes
    $error("N_DAC and N_CNT must be at least 1");
  end
  if ((DAC_LO == 0) || (CNT_LO == 0)) begin : g_chk_version
    $error("DAC/counter regions overlap the version register at address 0");
  end
  if (!((DAC_HI < CNT_LO) || (CNT_HI < DAC_LO))) begin : g_chk_overlap
    $error("DAC and counter regions overlap");
  end
  if ((DAC_HI > ADDR_MAX) || (CNT_HI > ADDR_MAX)) begin : g_chk_range
    $error("register region extends past the end of the address space");
  end

  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q,  rd_data_d;
  logic                rd_err_q,   rd_err_d;

  int unsigned         addr_u, dac_off, cnt_off, cnt_ch, cnt_k;
  logic                is_ver, is_dac, is_cnt;
  logic [DATA_W-1:0]   dac_byte, cnt_byte, live_byte;
  logic [CNT_W-1:0]    live_word;

`ifdef READBACK_SNAPSHOT_EN
  logic [CNT_W-1:0]    snap_reg_q, snap_reg_d;
  logic [CH_W-1:0]     snap_ch_q,  snap_ch_d;
  logic                snap_vld_q, snap_vld_d;
  logic [DATA_W-1:0]   snap_byte;
`endif

  always_comb begin
    addr_u  = 32'(rd_addr);
    is_ver  = (addr_u == 0);
    is_dac  = (addr_u >= DAC_LO) && (addr_u <= DAC_HI);
    is_cnt  = (addr_u >= CNT_LO) && (addr_u <= CNT_HI);
    dac_off = addr_u - DAC_LO;
    cnt_off = addr_u - CNT_LO;
    cnt_ch  = cnt_off / B;
    cnt_k   = cnt_off % B;

    // Constant-index loops keep the selects fixed-width; only the matching slice is picked.
    dac_byte = '0;
    for (int unsigned i = 0; i < N_DAC; i++) begin
      if (dac_off == i) dac_byte = dac_data[i*DATA_W +: DATA_W];
    end

    live_word = '0;
    for (int unsigned c = 0; c < N_CNT; c++) begin
      if (cnt_ch == c) live_word = cnt_data[c*CNT_W +: CNT_W];
    end

    live_byte = '0;
`ifdef READBACK_SNAPSHOT_EN
    snap_byte = '0;
`endif
    for (int unsigned j = 0; j < B; j++) begin
      if (cnt_k == j) begin
        live_byte = live_word[j*DATA_W +: DATA_W];
`ifdef READBACK_SNAPSHOT_EN
        snap_byte = snap_reg_q[j*DATA_W +: DATA_W];
`endif
      end
    end

`ifdef READBACK_SNAPSHOT_EN
    snap_reg_d = snap_reg_q;
    snap_ch_d  = snap_ch_q;
    snap_vld_d = snap_vld_q;
    cnt_byte   = live_byte;
    if (cnt_k == 0) begin
      // Byte 0 returns the live byte and captures the whole channel for the following bytes.
      if (rd_req && is_cnt) begin
        snap_reg_d = live_word;
        snap_ch_d  = CH_W'(cnt_ch);
        snap_vld_d = 1'b1;
      end
    end else if (snap_vld_q && (snap_ch_q == CH_W'(cnt_ch))) begin
      cnt_byte = snap_byte;
    end
`else
    cnt_byte = live_byte;
`endif

    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    if (rd_req) begin
      rd_err_d = 1'b0;
      if (is_ver)      rd_data_d = VERSION;
      else if (is_dac) rd_data_d = dac_byte;
      else if (is_cnt) rd_data_d = cnt_byte;
      else begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
`ifdef READBACK_SNAPSHOT_EN
      snap_reg_q <= '0;
      snap_ch_q  <= '0;
      snap_vld_q <= 1'b0;
`endif
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
`ifdef READBACK_SNAPSHOT_EN
      snap_reg_q <= snap_reg_d;
      snap_ch_q  <= snap_ch_d;
      snap_vld_q <= snap_vld_d;
`endif
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_readback_selector.sv
module tb_readback_selector;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req;
  logic [7:0]    rd_addr;
  logic [39:0]   dac_data;
  logic [1023:0] cnt_data;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_err;

  logic [7:0]  dac [5];
  logic [31:0] cnt [32];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: what the host would expect to see, tracked as plain values.
  logic [7:0]  last_d;
  logic        last_e;
  bit          m_snap_vld;
  int          m_snap_ch;
  logic [31:0] m_snap_val;

  always #5 clk = ~clk;

  always_comb begin
    dac_data = '0;
    cnt_data = '0;
    for (int i = 0; i < 5; i++)  dac_data[i*8 +: 8]   = dac[i];
    for (int c = 0; c < 32; c++) cnt_data[c*32 +: 32] = cnt[c];
  end

  readback_selector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .dac_data (dac_data),
    .cnt_data (cnt_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Address map: 0 = version 0x01, 2..6 = DAC 0..4, 0x26..0xA5 = 32 channels x 4 bytes, rest = error.
  task automatic model_read(input int a);
    int          ch, k;
    logic [31:0] w;
    last_e = 1'b0;
    last_d = 8'h00;
    if (a == 0) begin
      last_d = 8'h01;
    end else if (a >= 2 && a <= 6) begin
      last_d = dac[a-2];
    end else if (a >= 'h26 && a < 'h26 + 128) begin
      ch = (a - 'h26) / 4;
      k  = (a - 'h26) % 4;
      w  = cnt[ch];
`ifdef READBACK_SNAPSHOT_EN
      if (k == 0) begin
        m_snap_vld = 1'b1;
        m_snap_ch  = ch;
        m_snap_val = cnt[ch];
      end else if (m_snap_vld && m_snap_ch == ch) begin
        w = m_snap_val;
      end
`endif
      last_d = w[8*k +: 8];
    end else begin
      last_e = 1'b1;
    end
  endtask

  // One bus cycle: drive at the falling edge, check one cycle later just after the rising edge.
  task automatic step(input logic req, input int a);
    @(negedge clk);
    rd_req  = req;
    rd_addr = a[7:0];
    if (req) model_read(a);
    @(posedge clk);
    #1;
    check("rd_valid", 32'(rd_valid), 32'(req));
    check("rd_data",  32'(rd_data),  32'(last_d));
    check("rd_err",   32'(rd_err),   32'(last_e));
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_req  = 1'b0;
    rd_addr = 8'h00;
    for (int i = 0; i < 5; i++)  dac[i] = 8'(i + 8'h10);
    for (int c = 0; c < 32; c++) cnt[c] = 32'h1000_0000 + 32'(c);
    last_d = 8'h00; last_e = 1'b0;
    m_snap_vld = 1'b0; m_snap_ch = 0; m_snap_val = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_data",  32'(rd_data),  32'd0);
    check("reset_err",   32'(rd_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Version, DAC, unmapped
    step(1'b1, 'h00);
    check("version_const", 32'(rd_data), 32'h01);
    dac[2] = 8'h5A;
    step(1'b1, 'h04);
    check("dac2_const", 32'(rd_data), 32'h5A);
    step(1'b1, 'h07);
    check("unmapped07_err", 32'(rd_err), 32'd1);
    step(1'b1, 'h01);
    check("unmapped01_err", 32'(rd_err), 32'd1);

    // Coherent multi-byte read of channel 3
    cnt[3] = 32'hDEADBEEF;
    step(1'b1, 'h32);
    check("ch3_b0_const", 32'(rd_data), 32'hEF);
    cnt[3] = 32'h0000_0000;
    step(1'b1, 'h33);
`ifdef READBACK_SNAPSHOT_EN
    check("ch3_b1_const", 32'(rd_data), 32'hBE);
`else
    check("ch3_b1_const", 32'(rd_data), 32'h00);
`endif
    step(1'b1, 'h34);
    step(1'b1, 'h35);

    // Other channel while a snapshot is held: live byte, no error
    cnt[4] = 32'h11223344;
    step(1'b1, 'h37);
    check("ch4_b1_const", 32'(rd_data), 32'h33);

    // Back-to-back reads at full rate, including region boundaries
    step(1'b1, 'h00);
    step(1'b1, 'h02);
    step(1'b1, 'h26);
    step(1'b1, 'h27);
    step(1'b1, 'hA5);
    step(1'b1, 'hA6);
    check("a6_err_const", 32'(rd_err), 32'd1);
    step(1'b0, 'h00);

    // Reset while a request is in flight; afterwards no snapshot survives
    cnt[0] = 32'hAABBCCDD;
    step(1'b1, 'h26);
    cnt[0] = 32'h01020304;
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 8'h32;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 32'(rd_valid), 32'd0);
    check("rst_mid_data",  32'(rd_data),  32'd0);
    check("rst_mid_err",   32'(rd_err),   32'd0);
    m_snap_vld = 1'b0; m_snap_ch = 0; m_snap_val = '0;
    last_d = 8'h00; last_e = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    rd_req = 1'b0;
    step(1'b0, 'h00);
    step(1'b1, 'h27);
    check("post_rst_live", 32'(rd_data), 32'h03);

    // Randomized traffic against the reference model
    for (int it = 0; it < 400; it++) begin
      int sel, a;
      if ($urandom_range(0, 2) == 0) cnt[$urandom_range(0, 3)] = $urandom;
      if ($urandom_range(0, 7) == 0) dac[$urandom_range(0, 4)] = 8'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: a = 'h26 + $urandom_range(0, 15);
        5:             a = $urandom_range(0, 255);
        6:             a = $urandom_range(0, 8);
        7:             a = $urandom_range('hA3, 'hA8);
        default:       a = $urandom_range(0, 255);
      endcase
      step((sel == 8) ? 1'b0 : 1'b1, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
